// File: rtl/expr_eval.sv
// Single-digit '+'/'*' expression evaluator with precedence, driven by an ASCII stream.
// Results are registered; ok/err follow the recognizer state one clock after the consuming edge.
module expr_eval #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in,
  input  logic         in_valid,
  input  logic         clr,
  output logic [W-1:0] result,
  output logic         ok,
  output logic         err,
  output logic         ovf
);

  typedef enum logic [1:0] {START, NUM, OP, ERR} state_t;

  state_t       state, state_nx;
  logic [W-1:0] sum, term, sum_nx, term_nx, result_nx, new_term;
  logic         mul, mul_nx, ovf_nx;
  logic         is_digit, is_plus, is_star, prod_ovf;
  logic [3:0]   d;
  logic [W+3:0] prod;
  logic [W:0]   add_res, add_sum;

  assign is_digit = (in >= 8'h30) && (in <= 8'h39);
  assign is_plus  = (in == 8'h2b);
  assign is_star  = (in == 8'h2a);
  assign d        = in[3:0];

  // Product is kept 4 bits wider so a multiply overflow is visible before truncation.
  assign prod     = (W+4)'(term) * (W+4)'(d);
  assign prod_ovf = (state == OP) && mul && (|prod[W+3:W]);
  assign new_term = ((state == OP) && mul) ? prod[W-1:0] : W'(d);
  assign add_res  = {1'b0, sum} + {1'b0, new_term};
  assign add_sum  = {1'b0, sum} + {1'b0, term};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= START;
      sum    <= '0;
      term   <= '0;
      mul    <= 1'b0;
      result <= '0;
      ovf    <= 1'b0;
    end else begin
      state  <= state_nx;
      sum    <= sum_nx;
      term   <= term_nx;
      mul    <= mul_nx;
      result <= result_nx;
      ovf    <= ovf_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    sum_nx    = sum;
    term_nx   = term;
    mul_nx    = mul;
    result_nx = result;
    ovf_nx    = ovf;
    if (clr) begin
      state_nx  = START;
      sum_nx    = '0;
      term_nx   = '0;
      mul_nx    = 1'b0;
      result_nx = '0;
      ovf_nx    = 1'b0;
    end else if (in_valid) begin
      case (state)
        START, OP: begin
          if (is_digit) begin
            state_nx  = NUM;
            term_nx   = new_term;
            result_nx = add_res[W-1:0];
            ovf_nx    = ovf | prod_ovf | add_res[W];
          end else begin
            state_nx  = ERR;
            result_nx = '0;
          end
        end
        NUM: begin
          if (is_plus) begin
            state_nx = OP;
            sum_nx   = add_sum[W-1:0];
            term_nx  = '0;
            mul_nx   = 1'b0;
            ovf_nx   = ovf | add_sum[W];
          end else if (is_star) begin
            state_nx = OP;
            mul_nx   = 1'b1;
          end else begin
            state_nx  = ERR;
            result_nx = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ok  = (state == NUM);
    err = (state == ERR);
  end

endmodule

// File: tb/tb_expr_eval.sv
// Bench for expr_eval: directed scenarios plus a random character stream
// compared against a model that re-evaluates the accepted expression text.
module tb_expr_eval;
  localparam int W = 32;
  localparam longint unsigned M = 64'h1_0000_0000;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   in;
  logic         in_valid, clr;
  logic [W-1:0] result;
  logic         ok, err, ovf;

  int checks = 0, failures = 0;

  byte unsigned    ex[$];
  bit              m_err, m_ovf;
  longint unsigned exp_res;
  bit              exp_ok;

  expr_eval #(.W(W)) dut (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .clr(clr),
    .result(result), .ok(ok), .err(err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, expv);
    end
  endtask

  function automatic bit isdig(input byte unsigned c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  // Evaluate the accepted text with precedence, wrapping at 2^W and noting any overflow.
  function automatic longint unsigned evalx(output bit o);
    longint unsigned s = 0, t = 0;
    bit pm = 0;
    o = 0;
    foreach (ex[i]) begin
      if (isdig(ex[i])) begin
        if (pm) begin
          t = t * longint'(ex[i] - 8'h30);
          if (t >= M) o = 1;
          t = t % M;
        end else t = longint'(ex[i] - 8'h30);
        if (s + t >= M) o = 1;
      end else if (ex[i] == "+") begin
        s = s + t;
        if (s >= M) o = 1;
        s = s % M;
        t = 0;
        pm = 0;
      end else pm = 1;
    end
    return (s + t) % M;
  endfunction

  task automatic mreset();
    ex.delete();
    m_err = 0;
    m_ovf = 0;
  endtask

  task automatic mchar(input byte unsigned c);
    bit lastdig;
    if (m_err) return;
    lastdig = (ex.size() > 0) && isdig(ex[ex.size()-1]);
    if (!lastdig && isdig(c)) ex.push_back(c);
    else if (lastdig && (c == "+" || c == "*")) ex.push_back(c);
    else m_err = 1;
  endtask

  task automatic mout();
    bit o;
    if (m_err) begin
      exp_res = 0;
      exp_ok  = 0;
    end else begin
      exp_res = evalx(o);
      m_ovf   = m_ovf | o;
      exp_ok  = (ex.size() > 0) && isdig(ex[ex.size()-1]);
    end
  endtask

  task automatic cmp_all(input string tag);
    mout();
    chk({tag, ".result"}, 64'(result), exp_res);
    chk({tag, ".ok"}, 64'(ok), 64'(exp_ok));
    chk({tag, ".err"}, 64'(err), 64'(m_err));
    chk({tag, ".ovf"}, 64'(ovf), 64'(m_ovf));
  endtask

  task automatic step(input bit v, input byte unsigned c, input bit cl, input string tag);
    in = c; in_valid = v; clr = cl;
    @(posedge clk); #1;
    if (cl) mreset();
    else if (v) mchar(c);
    in_valid = 0; clr = 0; in = 8'h00;
    cmp_all(tag);
  endtask

  task automatic send(input string s, input int gap, input string tag);
    for (int i = 0; i < s.len(); i++) begin
      step(1'b1, s[i], 1'b0, tag);
      for (int g = 0; g < gap; g++) step(1'b0, 8'h35, 1'b0, {tag, ".gap"});
    end
  endtask

  initial begin
    byte unsigned c;
    int r;
    rst = 1; in = 0; in_valid = 0; clr = 0;
    mreset();
    #2;
    chk("rst.result", 64'(result), 0);
    chk("rst.ok", 64'(ok), 0);
    chk("rst.err", 64'(err), 0);
    chk("rst.ovf", 64'(ovf), 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 0;

    send("1+2*3", 0, "s034");
    chk("s034.r7", 64'(result), 7);
    chk("s034.ok", 64'(ok), 1);

    step(1'b0, 0, 1'b1, "clr");
    send("2*3*4", 2, "s035a");
    chk("s035.r24", 64'(result), 24);
    send("+5", 3, "s035b");
    chk("s035.r29", 64'(result), 29);

    step(1'b0, 0, 1'b1, "clr");
    send("1+", 0, "s036a");
    chk("s036.op_ok", 64'(ok), 0);
    chk("s036.op_r", 64'(result), 1);
    send("+", 0, "s036b");
    chk("s036.err", 64'(err), 1);
    chk("s036.r0", 64'(result), 0);
    send("5", 0, "s036c");
    chk("s036.sticky", 64'(err), 1);

    step(1'b0, 0, 1'b1, "clr");
    send("9", 0, "s037");
    for (int i = 0; i < 10; i++) begin
      send("*9", 0, "s037");
      if (i == 8) begin
        chk("s037.r10", 64'(result), 64'd3486784401);
        chk("s037.ovf10", 64'(ovf), 0);
      end
    end
    chk("s037.r11", 64'(result), 64'd1316288537);
    chk("s037.ovf11", 64'(ovf), 1);

    step(1'b0, 0, 1'b1, "clr");
    send("4*5", 0, "s038a");
    step(1'b1, "7", 1'b1, "s038clr");
    send("3", 0, "s038b");
    chk("s038.r3", 64'(result), 3);
    chk("s038.ok", 64'(ok), 1);

    step(1'b0, 0, 1'b1, "clr");
    send("8+", 0, "s039a");
    @(negedge clk); #2;
    rst = 1; #1;
    chk("s039.async_r", 64'(result), 0);
    chk("s039.async_ok", 64'(ok), 0);
    mreset();
    #1 rst = 0;
    send("6", 0, "s039b");
    chk("s039.r6", 64'(result), 6);
    chk("s039.ok", 64'(ok), 1);

    // Random stream: mostly legal tokens, occasional junk, gaps and restarts.
    step(1'b0, 0, 1'b1, "clr");
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 39);
      if (r < 20) c = 8'(8'h30 + $urandom_range(0, 9));
      else if (r < 28) c = "+";
      else if (r < 37) c = "*";
      else if (r == 37) c = " ";
      else c = 8'($urandom_range(0, 255));
      step($urandom_range(0, 3) != 0, c, $urandom_range(0, 29) == 0, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/expr_eval.md
EXPR_EVAL -- requirements
Module: expr_eval

Interface
REQ-001 Parameter W, default 32, width of result and internal accumulators.
REQ-002 clk  input  1  clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in  input  8  ASCII character; same character stream the upstream recognizer consumes.
REQ-005 in_valid  input  1  strobe; in is consumed on a rising edge where in_valid=1.
REQ-006 clr  input  1  synchronous restart; begins a new expression.
REQ-007 result  output  W  value of the expression so far, modulo 2^W.
REQ-008 ok  output  1  expression so far is complete and well-formed (ends in a digit).
REQ-009 err  output  1  sticky syntax error.
REQ-010 ovf  output  1  sticky arithmetic overflow.

Function
REQ-011 Grammar: digit ( ('+'|'*') digit )*, where digit is "0".."9" (8'h30..8'h39) and each operand is a single digit.
REQ-012 Evaluation uses standard precedence: '*' binds tighter than '+'.
REQ-013 FSM states: START (expect first digit), NUM (digit just accepted), OP (operator just accepted), ERR.
REQ-014 START: on digit -> NUM; on any other character -> ERR.
REQ-015 NUM: on '+' or '*' -> OP; on any other character -> ERR.
REQ-016 OP: on digit -> NUM; on any other character -> ERR.
REQ-017 ERR: remains in ERR regardless of in_valid or in until clr or rst.
REQ-018 When in_valid=0 and clr=0, all state and outputs hold.
REQ-019 Internal registers:
- sum (W bits), total of completed additive terms.
- term (W bits), current multiplicative term.
- mul (1 bit), set when the last operator was '*'.
REQ-020 Digit accepted in START, or in OP with mul=0: term <= d.
REQ-021 Digit accepted in OP with mul=1: term <= term*d, truncated to W bits.
REQ-022 '+' accepted: sum <= sum+term (W bits); term <= 0; mul <= 0.
REQ-023 '*' accepted: mul <= 1; sum and term unchanged.
REQ-024 On each accepted digit, result <= sum + new term (W bits). The value is registered and visible the cycle after the edge.
REQ-025 Latency: exactly one clock from the consuming edge to the updated result, ok, err and ovf.
REQ-026 ok=1 exactly when the state is NUM. In OP, result holds its last value and ok=0.
REQ-027 Entering ERR sets err=1, sets ok=0 and clears result to 0.
REQ-028 ovf is set when the exact value of any product or sum in REQ-021/022/024 is 2^W or greater. ovf is sticky, and evaluation continues with the wrapped value.
REQ-029 clr=1 on an edge:
- state <= START; sum, term, mul, result, ok, err, ovf <= 0.
- clr takes priority over in_valid; a character presented in that cycle is discarded.
REQ-030 Characters other than digits, '+' and '*' (including space and NUL) are syntax errors wherever they appear.

Reset
REQ-031 rst=1 forces state=START; sum, term, mul, result, ok, err, ovf = 0 immediately, independent of clk.
REQ-032 Reset asserted mid-expression discards all partial evaluation. The first valid character after release is treated as the start of a new expression.
REQ-033 rst deassertion takes effect at the next rising clk. A character strobed on that edge is consumed normally.

Verification
REQ-034 Stream "1+2*3", one character per cycle -> ok=1 and result=7 one cycle after the '3' edge; err=0; ovf=0.
REQ-035 Stream "2*3*4+5" with in_valid gaps between characters -> result=24 after '4', then 29 after '5'; values hold during gaps.
REQ-036 Stream "1++" -> after '1' result=1, ok=1; after first '+' ok=0, result=1; after second '+' err=1, result=0; a later "5" leaves err=1.
REQ-037 Stream "9" followed by ten repetitions of "*9" (W=32):
- after the 10th digit: result=3486784401, ovf=0.
- after the 11th digit: result=1316288537, ovf=1.
REQ-038 Stream "4*5", then clr=1 together with in_valid=1 and in="7", then "3":
- the '7' is discarded.
- after '3': result=3, ok=1, err=0, ovf=0.
REQ-039 Stream "8+", then rst pulsed asynchronously between clock edges:
- outputs go to 0 at once.
- a subsequent "6" yields result=6, ok=1.
